// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode encodings and the
// controller state encoding.
// Optional build macro used elsewhere in this slice: ALU_SIGNED_MUL_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_nb_if.sv
// -----------------------------------------------------------------------------
// alu_seq_nb_if
// Operand/result handshake bundle of the sequential ALU.
//   master : issues operations and accepts results (operand side + writeback)
//   slave  : the ALU itself
// Signals: in_valid/in_ready, a, b, opcode, out_valid/out_ready, result (2W),
//          cout, zero, ovf.
// -----------------------------------------------------------------------------
interface alu_seq_nb_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     opcode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           cout;
  logic           zero;
  logic           ovf;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, cout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, cout, zero, ovf
  );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Iterative radix-2 shift-add multiplier, one multiplier bit per cycle,
// W cycles per product.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b and begin (ignored result of any running product)
//   a, b       : multiplicand / multiplier, sampled on start
//   done       : high in the cycle of the final step; product is valid then
//   product    : 2W-bit product (meaningful while done is high)
// Macro ALU_SIGNED_MUL_EN: signed two's-complement product (sign-extended
// accumulation, MSB step subtracts); otherwise unsigned.
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mcand_q, mcand_d;
  // upper half: partial sum, lower half: remaining multiplier bits
  logic [2*W-1:0] prod_q, prod_d;
  logic [W:0]     addend;
  logic [W:0]     sum;

  always_comb begin
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    addend  = '0;
    sum     = '0;
    done    = 1'b0;
    if (start) begin
      cnt_d   = CW'(W);
      mcand_d = a;
      prod_d  = {{W{1'b0}}, b};
    end else if (cnt_q != '0) begin
`ifdef ALU_SIGNED_MUL_EN
      addend = prod_q[0] ? {mcand_q[W-1], mcand_q} : '0;
      // multiplier MSB carries negative weight
      if (cnt_q == CW'(1))
        sum = {prod_q[2*W-1], prod_q[2*W-1:W]} - addend;
      else
        sum = {prod_q[2*W-1], prod_q[2*W-1:W]} + addend;
`else
      addend = prod_q[0] ? {1'b0, mcand_q} : '0;
      sum    = {1'b0, prod_q[2*W-1:W]} + addend;
`endif
      prod_d = {sum, prod_q[W-1:1]};
      cnt_d  = cnt_q - 1'b1;
      done   = (cnt_q == CW'(1));
    end
  end

  // exposing the next value lets the caller capture on the final step edge
  assign product = prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/alu_seq_nb.sv
// -----------------------------------------------------------------------------
// alu_seq_nb
// Clocked W-bit ALU with valid/ready handshake, 2W-bit result and flags.
// Non-mul ops: 2 cycles accept->out_valid. Mul: W+1 cycles via alu_mul_seq.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_nb_if.slave (in_valid/in_ready, a, b, opcode,
//                out_valid/out_ready, result, cout, zero, ovf)
// Macro ALU_SIGNED_MUL_EN: opcode 010 gives a signed product.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for an operation
// EXEC    | one-cycle compute of non-mul ops
// MUL     | shift-add multiplier running for W cycles
// DONE    | out_valid=1, outputs held until out_ready
// -----------------------------------------------------------------------------
module alu_seq_nb
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_nb_if.slave bus
);

  state_e         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [2*W-1:0] result_q, result_d;
  logic           cout_q, cout_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2:0]     op_q, op_d;

  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_product;

  logic [W:0]     sum_w;
  logic [W:0]     diff_w;
  logic [W-1:0]   sh_w;
  logic [2*W-1:0] res_w;

  alu_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    mul_start   = 1'b0;
    sum_w       = {1'b0, a_q} + {1'b0, b_q};
    diff_w      = {1'b0, a_q} - {1'b0, b_q};
    sh_w        = '0;
    res_w       = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          op_d       = bus.opcode;
          in_ready_d = 1'b0;
          if (bus.opcode == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (op_q)
          OP_ADD: begin
            res_w  = {{(W-1){1'b0}}, sum_w};
            cout_d = sum_w[W];
            ovf_d  = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
          end
          OP_SUB: begin
            res_w  = {{W{1'b0}}, diff_w[W-1:0]};
            cout_d = diff_w[W];
            ovf_d  = (a_q[W-1] != b_q[W-1]) && (diff_w[W-1] != a_q[W-1]);
          end
          OP_SHL: begin
            sh_w  = a_q << b_q[SHW-1:0];
            res_w = {{W{1'b0}}, sh_w};
          end
          OP_SHR: begin
            sh_w  = a_q >> b_q[SHW-1:0];
            res_w = {{W{1'b0}}, sh_w};
          end
          OP_AND:  res_w = {{W{1'b0}}, a_q & b_q};
          OP_OR:   res_w = {{W{1'b0}}, a_q | b_q};
          OP_XOR:  res_w = {{W{1'b0}}, a_q ^ b_q};
          default: res_w = '0;
        endcase
        result_d    = res_w;
        zero_d      = (res_w == '0);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end

      ST_MUL: begin
        if (mul_done) begin
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          cout_d      = 1'b0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq_nb.sv
module tb_alu_seq_nb;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  alu_seq_nb_if #(.W(8))  bus8 ();
  alu_seq_nb_if #(.W(16)) bus16 ();

  alu_seq_nb #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  alu_seq_nb #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

`ifdef ALU_SIGNED_MUL_EN
  localparam logic [15:0] MUL_FF_FF = 16'h0001;
  localparam logic [15:0] MUL_FF_02 = 16'hFFFE;
`else
  localparam logic [15:0] MUL_FF_FF = 16'hFE01;
  localparam logic [15:0] MUL_FF_02 = 16'h01FE;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        o;
    int          lat;
    bit          early;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready8(input string nm);
    int g = 0;
    while (bus8.in_ready !== 1'b1 && g < 20) begin
      @(posedge clk); #1; g++;
    end
    chk(nm, {31'd0, bus8.in_ready}, 32'd1);
  endtask

  task automatic run8(input vec_t v, input int idx);
    int lat;
    wait_ready8($sformatf("v%0d ready", idx));
    bus8.out_ready = v.early;
    bus8.a         = v.a;
    bus8.b         = v.b;
    bus8.opcode    = v.op;
    bus8.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    chk($sformatf("v%0d in_ready_drop", idx), {31'd0, bus8.in_ready}, 32'd0);
    lat = 1;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.lat);
    chk($sformatf("v%0d result", idx), {16'd0, bus8.result}, {16'd0, v.res});
    chk($sformatf("v%0d cout", idx), {31'd0, bus8.cout}, {31'd0, v.c});
    chk($sformatf("v%0d zero", idx), {31'd0, bus8.zero}, {31'd0, v.z});
    chk($sformatf("v%0d ovf", idx), {31'd0, bus8.ovf}, {31'd0, v.o});
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk($sformatf("v%0d out_valid_clr", idx), {31'd0, bus8.out_valid}, 32'd0);
    chk($sformatf("v%0d in_ready_ret", idx), {31'd0, bus8.in_ready}, 32'd1);
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string nm);
    int lat;
    int g = 0;
    while (bus16.in_ready !== 1'b1 && g < 20) begin
      @(posedge clk); #1; g++;
    end
    bus16.a        = a;
    bus16.b        = b;
    bus16.opcode   = op;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, " latency"}, lat, 2);
    chk({nm, " result"}, bus16.result, exp);
    chk({nm, " zero"}, {31'd0, bus16.zero}, {31'd0, (exp == 32'd0)});
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    chk({nm, " out_valid_clr"}, {31'd0, bus16.out_valid}, 32'd0);
  endtask

  initial begin
    //          op      a      b      res        c     z     o    lat early
    vecs[0]  = '{OP_ADD, 8'hF0, 8'h30, 16'h0120, 1'b1, 1'b0, 1'b0, 2, 1'b0};
    vecs[1]  = '{OP_ADD, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vecs[2]  = '{OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b0, 2, 1'b0};
    vecs[3]  = '{OP_SUB, 8'h10, 8'h50, 16'h00C0, 1'b1, 1'b0, 1'b0, 2, 1'b0};
    vecs[4]  = '{OP_SUB, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    vecs[5]  = '{OP_SUB, 8'h33, 8'h33, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 1'b0};
    vecs[6]  = '{OP_MUL, 8'hFF, 8'hFF, MUL_FF_FF, 1'b0, 1'b0, 1'b0, 9, 1'b0};
    vecs[7]  = '{OP_MUL, 8'h0C, 8'h0D, 16'h009C, 1'b0, 1'b0, 1'b0, 9, 1'b0};
    vecs[8]  = '{OP_MUL, 8'hFF, 8'h02, MUL_FF_02, 1'b0, 1'b0, 1'b0, 9, 1'b0};
    vecs[9]  = '{OP_SHL, 8'h81, 8'h03, 16'h0008, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    vecs[10] = '{OP_SHR, 8'h80, 8'h08, 16'h0080, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    vecs[11] = '{OP_SHR, 8'hF0, 8'h04, 16'h000F, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    vecs[12] = '{OP_AND, 8'hAA, 8'h0F, 16'h000A, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    vecs[13] = '{OP_OR,  8'hA0, 8'h05, 16'h00A5, 1'b0, 1'b0, 1'b0, 2, 1'b1};
    vecs[14] = '{OP_XOR, 8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 1'b0};
    vecs[15] = '{OP_SHL, 8'h01, 8'h07, 16'h0080, 1'b0, 1'b0, 1'b0, 2, 1'b0};

    rst_n = 1'b0;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.opcode = OP_ADD;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.opcode = OP_ADD;

    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", {31'd0, bus8.in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, bus8.out_valid}, 32'd0);
    chk("rst result", {16'd0, bus8.result}, 32'd0);
    chk("rst flags", {29'd0, bus8.cout, bus8.zero, bus8.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst in_ready", {31'd0, bus8.in_ready}, 32'd1);

    for (int i = 0; i < 16; i++) run8(vecs[i], i);

    run16(OP_SHL, 16'h0001, 16'h000F, 32'h0000_8000, "w16 shl");
    run16(OP_SHR, 16'h8000, 16'h0013, 32'h0000_1000, "w16 shr");

    // backpressure: result held while out_ready low, in_valid pulses ignored
    wait_ready8("bp ready");
    bus8.a = 8'hAA; bus8.b = 8'h0F; bus8.opcode = OP_AND; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    for (int g = 0; g < 10 && bus8.out_valid !== 1'b1; g++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = (i % 2 == 0);
      bus8.a = 8'h01; bus8.b = 8'h01; bus8.opcode = OP_ADD;
      @(posedge clk); #1;
      chk($sformatf("bp%0d result", i), {16'd0, bus8.result}, 32'h000A);
      chk($sformatf("bp%0d out_valid", i), {31'd0, bus8.out_valid}, 32'd1);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk("bp release", {31'd0, bus8.out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp no_queue", {31'd0, bus8.out_valid}, 32'd0);

    // reset in the middle of a multiply
    wait_ready8("rm ready");
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.opcode = OP_MUL; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rm busy", {31'd0, bus8.out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rm in_ready", {31'd0, bus8.in_ready}, 32'd0);
    chk("rm result", {16'd0, bus8.result}, 32'd0);
    chk("rm flags", {28'd0, bus8.out_valid, bus8.cout, bus8.zero, bus8.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rm in_ready_after", {31'd0, bus8.in_ready}, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("rm no_stale", {31'd0, bus8.out_valid}, 32'd0);
    run8('{OP_XOR, 8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 1'b0}, 100);
    run8('{OP_MUL, 8'h0C, 8'h0D, 16'h009C, 1'b0, 1'b0, 1'b0, 9, 1'b0}, 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_nb.md
Name: alu_seq_nb

Overview:
- Parametrised, clocked successor to the 8-bit combinational ALU: operand width W, registered valid/ready handshake, multi-cycle shift-add multiplier, and status flags.
- Sits between the operand register file and the result writeback stage.
- Accepts one operation at a time and returns a 2W-bit result plus flags.

Parameters:
- W, 8: operand width in bits, legal range 4..32.
- SHW, $clog2(W): number of shift-amount bits taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode presented this cycle.
- in_ready  output  1  block can accept a new operation.
- a  input  W  operand A.
- b  input  W  operand B; for shifts, the amount is b[SHW-1:0].
- opcode  input  3  000 add, 001 sub, 010 mul, 011 shl, 100 shr, 101 and, 110 or, 111 xor.
- out_valid  output  1  result is valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- result  output  2W  zero-extended result; mul gives the full 2W-bit product.
- cout  output  1  carry out for add; borrow (a<b unsigned) for sub; 0 otherwise.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow for add/sub; 0 otherwise.

Behaviour:
- Reset (async, rst_n=0):
  - in_ready=0 while reset is asserted, then 1 from the first cycle after release.
  - out_valid=0, result=0, cout=0, zero=0, ovf=0.
  - State goes to IDLE.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE, accepting (in_valid&&in_ready):
  - Latch a, b and opcode; in_ready drops to 0.
  - Non-mul opcodes go to EXEC; mul goes to MUL with count=W.
- EXEC: compute for one cycle, register result and flags, go to DONE.
  - Non-mul latency is 2 cycles from accept to out_valid.
- MUL: radix-2 shift-add, one bit per cycle for W cycles, then DONE.
  - Mul latency is W+1 cycles from accept to out_valid.
- DONE: out_valid=1 and outputs held stable.
  - On out_ready: out_valid=0 in the next cycle, in_ready=1 in the next cycle, state back to IDLE.
  - out_ready held high before DONE has no effect.
- Add: result[W:0] = a+b with bit W = cout; upper bits zero.
- Sub: result = (a-b) mod 2^W, zero-extended; cout=1 when borrowing.
- Shifts:
  - Logical shift, zero fill, within W bits; upper W bits of result are zero.
  - Amount = b[SHW-1:0]; bits of b above SHW are ignored, so b=W behaves as a shift of 0.
- and/or/xor: W-bit result, zero-extended.
- Status flags:
  - ovf for add: sign(a)==sign(b) and sign(sum)!=sign(a).
  - ovf for sub: sign(a)!=sign(b) and sign(diff)!=sign(a).
  - zero is evaluated on the full 2W-bit result.
- in_valid while busy is ignored; no queueing.
- Reset mid-operation: any partial product or pending result is discarded.

Optional Feature:
- ALU_SIGNED_MUL_EN defined:
  - Opcode 010 computes a signed two's-complement product (Baugh-Wooley or sign-corrected shift-add) over W cycles.
  - ovf=0 and cout=0 for this opcode.
- Not defined: opcode 010 is an unsigned product.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_XOR) and FSM state encodings.
- One sub-module, alu_mul_seq: the iterative multiplier.
  - Interface: start, a, b, done, product.
  - Owns the cycle counter and the partial-product register.

Test Plan:
- W=8: add a=F0, b=30 -> result=0120, cout=1, zero=0, ovf=0; out_valid exactly 2 cycles after accept.
- W=8: sub a=10, b=50 -> result=00C0, cout=1; sub a=80, b=01 -> result=007F, ovf=1.
- W=8: mul a=FF, b=FF -> result=FE01, out_valid 9 cycles after accept.
  - With ALU_SIGNED_MUL_EN: result=0001.
- W=16: shl a=0001, b=000F -> result=00008000.
  - shr a=8000, b=0013 -> amount 3, result=00001000.
- Backpressure, W=8: out_ready held 0 for 5 cycles after and a=AA, b=0F.
  - result=000A stays stable with out_valid=1 throughout.
  - in_valid pulses in that window are ignored.
- Reset mid-mul: assert rst_n=0 at cycle 4 of a mul.
  - All outputs return to 0 asynchronously.
  - After release, xor a=FF, b=FF -> result=0000, zero=1.
